stamp_logger: RTL and testbench

- Downstream consumer of the timestamp/zero stream produced by the input-gated wallclock stage.
- Each cycle it samples that stage's 64-bit output and detects new non-zero timestamps.
- For each new timestamp it records the value and the delta from the previous capture in a small FIFO.
- Entries drain through a valid/ready interface.
- All ports are public (L) data. No behaviour, latency or handshake timing may depend on anything but port values.

---
 rtl/stamp_logger.sv | 97 +++++++++
 tb/tb_stamp_logger.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stamp_logger.sv
// rtl/stamp_logger.sv - captures new non-zero timestamps with inter-capture deltas
// into a show-ahead FIFO drained through a valid/ready port.
module stamp_logger #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int CW    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [63:0]              in_stamp,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [63:0]              out_stamp,
   output logic [DW-1:0]            out_delta,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic [CW-1:0]            drop_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [63:0]   mem_stamp [DEPTH];
   logic [DW-1:0] mem_delta [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [63:0]   prev_sample, last_cap, diff;
   logic          have_cap, evt, pop, push, drop;
   logic [DW-1:0] delta;

   assign out_valid = (count != '0);
   assign full      = (count == CNTW'(DEPTH));
   assign pop       = out_valid && out_ready;
   assign evt       = (in_stamp != 64'd0) && (in_stamp != prev_sample);
   assign push      = evt && (!full || pop);
   assign drop      = evt && full && !pop;
   assign diff      = in_stamp - last_cap;

   // Backward jumps and oversized gaps both report the saturated delta.
   always_comb begin
      delta = '0;
      if (have_cap) begin
         if ((in_stamp < last_cap) || (|(diff >> DW)))
            delta = '1;
         else
            delta = diff[DW-1:0];
      end
   end

   assign out_stamp = out_valid ? mem_stamp[rd_ptr] : 64'd0;
   assign out_delta = out_valid ? mem_delta[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_stamp[wr_ptr] <= in_stamp;
         mem_delta[wr_ptr] <= delta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sample <= '0;
         last_cap    <= '0;
         have_cap    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         drop_cnt    <= '0;
      end else begin
         // Sampling continues through flush so a held stamp stays suppressed.
         prev_sample <= in_stamp;
         if (flush) begin
            last_cap <= '0;
            have_cap <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + 1'b1;
               last_cap <= in_stamp;
               have_cap <= 1'b1;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
            if (drop && (drop_cnt != '1))
               drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stamp_logger.sv
// tb/tb_stamp_logger.sv - directed scoreboard bench for stamp_logger.
module tb_stamp_logger;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [63:0] s;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic [63:0] in_stamp;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_stamp;
   logic [31:0] out_delta;
   logic [2:0]  count;
   logic        full;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   ent_t        sb[$];
   logic [63:0] m_prev, m_last;
   logic        m_have;
   logic [15:0] m_drop;

   stamp_logger #(.DEPTH(DEPTH), .DW(32), .CW(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_stamp  (in_stamp),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_stamp (out_stamp),
      .out_delta (out_delta),
      .count     (count),
      .full      (full),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mdelta(input logic [63:0] s);
      if (!m_have) return 32'd0;
      if (s < m_last) return 32'hFFFF_FFFF;
      if ((s - m_last) > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return 32'(s - m_last);
   endfunction

   task automatic model_clear();
      sb.delete();
      m_last = 64'd0;
      m_have = 1'b0;
      m_drop = 16'd0;
   endtask

   // Drives one cycle from posedge+1, checks the head, updates the model, checks state after the edge.
   task automatic step(input logic [63:0] s, input logic rdy);
      ent_t e;
      bit   p, ev;
      in_stamp  = s;
      out_ready = rdy;
      #1;
      if (sb.size() > 0) begin
         chk("valid", 64'(out_valid), 64'd1);
         chk("head_stamp", out_stamp, sb[0].s);
         chk("head_delta", 64'(out_delta), 64'(sb[0].d));
      end else begin
         chk("valid_empty", 64'(out_valid), 64'd0);
         chk("stamp_empty", out_stamp, 64'd0);
         chk("delta_empty", 64'(out_delta), 64'd0);
      end
      p  = (sb.size() > 0) && rdy;
      ev = (s != 64'd0) && (s != m_prev);
      if (ev) begin
         if ((sb.size() < DEPTH) || p) begin
            e.s = s;
            e.d = mdelta(s);
            m_last = s;
            m_have = 1'b1;
            if (p) void'(sb.pop_front());
            p = 1'b0;
            sb.push_back(e);
         end else if (m_drop != 16'hFFFF) begin
            m_drop++;
         end
      end
      if (p) void'(sb.pop_front());
      m_prev = s;
      @(posedge clk);
      #1;
      chk("count", 64'(count), 64'(sb.size()));
      chk("full", 64'(full), 64'(sb.size() == DEPTH));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
   endtask

   task automatic do_flush(input logic [63:0] s, input logic rdy);
      in_stamp  = s;
      out_ready = rdy;
      flush     = 1'b1;
      model_clear();
      m_prev = s;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_drop", 64'(drop_cnt), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_stamp  = 64'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      m_prev    = 64'd0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_stamp", out_stamp, 64'd0);
      chk("rst_delta", 64'(out_delta), 64'd0);
      rst_n = 1'b1;

      // Idle zeros
      for (int i = 0; i < 10; i++) step(64'd0, 1'b0);

      // Held stamp captured once, then 9
      for (int i = 0; i < 3; i++) step(64'd5, 1'b0);
      step(64'd9, 1'b0);
      chk("t2_count", 64'(count), 64'd2);
      step(64'd9, 1'b0);
      step(64'd9, 1'b1);
      step(64'd9, 1'b1);
      step(64'd9, 1'b0);

      // Overflow: 10..60 into DEPTH=4, then push+pop while full
      do_flush(64'd9, 1'b0);
      for (int i = 1; i <= 6; i++) step(64'(i * 10), 1'b0);
      chk("t3_full", 64'(full), 64'd1);
      chk("t3_drop", 64'(drop_cnt), 64'd2);
      step(64'd100, 1'b1);
      chk("t4_count", 64'(count), 64'd4);
      chk("t4_drop", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 5; i++) step(64'd100, 1'b1);

      // Saturation and backward jump
      step(64'h1_0000_0000, 1'b1);
      step(64'h3_0000_0000, 1'b1);
      step(64'h2, 1'b1);
      for (int i = 0; i < 3; i++) step(64'h2, 1'b1);

      // Flush while stamp held
      step(64'd71, 1'b0);
      step(64'd72, 1'b0);
      step(64'd77, 1'b0);
      chk("t6_pre_count", 64'(count), 64'd3);
      do_flush(64'd77, 1'b0);
      step(64'd77, 1'b0);
      step(64'd77, 1'b0);
      step(64'd80, 1'b0);
      step(64'd81, 1'b0);

      // Asynchronous reset mid-drain
      in_stamp  = 64'd81;
      out_ready = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_stamp", out_stamp, 64'd0);
      chk("arst_drop", 64'(drop_cnt), 64'd0);
      in_stamp  = 64'd0;
      out_ready = 1'b0;
      model_clear();
      m_prev = 64'd0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(64'd300, 1'b1);
      step(64'd310, 1'b1);
      for (int i = 0; i < 3; i++) step(64'd310, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
